// File: rtl/cordic_arbiter_pkg.sv
// Shared types and constants for the CORDIC request arbiter.
package cordic_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester/response bundle between the clients and the CORDIC arbiter.
interface cordic_arbiter_if import cordic_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_dataa;
  logic [NUM_REQ-1:0]    req_cos;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic [31:0]           resp_data;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_ready;

  modport master (
    output req_valid, req_dataa, req_cos, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_dataa, req_cos, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/cordic_rr_picker.sv
// Round-robin selector: first valid request at or above ptr, wrapping.
module cordic_rr_picker import cordic_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int ID_W = $clog2(NUM_REQ);

  int              pos;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = ID_W'(pos);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC engine among NUM_REQ requesters with round-robin grant.
// Optional watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter import cordic_arbiter_pkg::*; #(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  cordic_arbiter_if.slave  bus,
  output logic             eng_start,
  output logic [31:0]      eng_dataa,
  output logic             eng_cos,
  input  logic             eng_done,
  input  logic [31:0]      eng_result,
  output logic             busy
);
  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cordic_arbiter: parameter out of range");
  end

  arb_state_t         state, state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               timeout_fire;
  logic [31:0]        sel_dataa;
  logic               sel_cos;

  cordic_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_dataa = '0;
    sel_cos   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_dataa = bus.req_dataa[32*i +: 32];
        sel_cos   = bus.req_cos[i];
      end
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_fire = (state == ST_WAIT) && !eng_done &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (clk_en) begin
      if (state != ST_WAIT) wait_cnt <= '0;
      else if (!timeout_fire) wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else if (clk_en) state <= state_next;
  end

  // req_ready is gated by reset so a held request never shows a grant while in reset
  always_comb begin
    state_next    = state;
    bus.req_ready = '0;
    eng_start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_next = ST_ISSUE;
          if (clk_en && !reset) bus.req_ready = pick_grant;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
        eng_start  = clk_en;
      end
      ST_WAIT: begin
        if (eng_done || timeout_fire) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy           = (state != ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      eng_dataa     <= '0;
      eng_cos       <= 1'b0;
      bus.resp_id   <= '0;
      bus.resp_data <= '0;
    end else if (clk_en) begin
      if (state == ST_IDLE && pick_any) begin
        rr_ptr      <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        eng_dataa   <= sel_dataa;
        eng_cos     <= sel_cos;
        bus.resp_id <= pick_idx;
      end
      if (state == ST_WAIT) begin
        if (eng_done) bus.resp_data <= eng_result;
        else if (timeout_fire) bus.resp_data <= QNAN;
      end
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter; exercises the watchdog when
// CORDIC_ARB_TIMEOUT_EN is defined.
module tb_cordic_arbiter;
  import cordic_arbiter_pkg::*;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        eng_start;
  logic [31:0] eng_dataa;
  logic        eng_cos;
  logic        eng_done;
  logic [31:0] eng_result;
  logic        busy;

  cordic_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  cordic_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .bus        (bus),
    .eng_start  (eng_start),
    .eng_dataa  (eng_dataa),
    .eng_cos    (eng_cos),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] dataa;
    logic        cos;
    logic [31:0] result;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int id, input logic [31:0] dataa, input logic cos);
    bus.req_valid     = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_dataa[32*id +: 32] = dataa;
    bus.req_cos[id]   = cos;
  endtask

  task automatic waitReady(output logic [3:0] got);
    got = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        got = bus.req_ready;
        return;
      end
      tick();
    end
  endtask

  task automatic driveDone(input logic [31:0] result, input logic [1:0] id);
    exp_t e;
    e.data = result;
    e.id   = id;
    sb_q.push_back(e);
    eng_done   = 1'b1;
    eng_result = result;
    tick();
    eng_done   = 1'b0;
  endtask

  task automatic waitResp();
    exp_t e;
    for (int c = 0; c < 40 && !bus.resp_valid; c++) tick();
    checkOutput("resp_valid", 32'(bus.resp_valid), 32'd1);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_underflow actual=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      checkOutput("resp_data", bus.resp_data, e.data);
      checkOutput("resp_id", 32'(bus.resp_id), 32'(e.id));
    end
  endtask

  task automatic finishResp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    logic [3:0] got;
    applyStimulus(v.id, v.dataa, v.cos);
    waitReady(got);
    checkOutput("req_ready", 32'(got), 32'(v.exp_ready));
    tick();
    bus.req_valid = '0;
    checkOutput("eng_start", 32'(eng_start), 32'd1);
    checkOutput("eng_dataa", eng_dataa, v.dataa);
    checkOutput("eng_cos", 32'(eng_cos), 32'(v.cos));
    checkOutput("busy_issue", 32'(busy), 32'd1);
    tick();
    checkOutput("eng_start_once", 32'(eng_start), 32'd0);
    checkOutput("resp_valid_wait", 32'(bus.resp_valid), 32'd0);
    driveDone(v.result, 2'(v.id));
    waitResp();
    finishResp();
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, "_resp_data"}, bus.resp_data, 32'd0);
    checkOutput({tag, "_resp_id"}, 32'(bus.resp_id), 32'd0);
    checkOutput({tag, "_eng_dataa"}, eng_dataa, 32'd0);
    checkOutput({tag, "_eng_cos"}, 32'(eng_cos), 32'd0);
    checkOutput({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t       vecs[4];
    logic [3:0] got;
    int         n;

    vecs[0] = '{2, 32'h3F800000, 1'b1, 32'h3F0A5140, 4'b0100};
    vecs[1] = '{0, 32'h40490FDB, 1'b0, 32'hB3BBBD2E, 4'b0001};
    vecs[2] = '{3, 32'hBF000000, 1'b1, 32'h3F60A940, 4'b1000};
    vecs[3] = '{1, 32'h00000000, 1'b0, 32'h00000001, 4'b0010};

    reset          = 1'b1;
    clk_en         = 1'b1;
    eng_done       = 1'b0;
    eng_result     = '0;
    bus.req_valid  = '0;
    bus.req_dataa  = '0;
    bus.req_cos    = '0;
    bus.resp_ready = 1'b0;
    repeat (3) tick();
    checkResetOutputs("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) runVector(vecs[i]);

    // clk_en low freezes the grant and the ISSUE state
    clk_en = 1'b0;
    applyStimulus(1, 32'h11111111, 1'b1);
    #1;
    checkOutput("gated_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (3) tick();
    checkOutput("gated_busy", 32'(busy), 32'd0);
    clk_en = 1'b1;
    waitReady(got);
    checkOutput("en_req_ready", 32'(got), 32'h2);
    tick();
    bus.req_valid = '0;
    clk_en = 1'b0;
    #1;
    checkOutput("gated_eng_start", 32'(eng_start), 32'd0);
    tick();
    checkOutput("frozen_busy", 32'(busy), 32'd1);
    checkOutput("frozen_eng_dataa", eng_dataa, 32'h11111111);
    clk_en = 1'b1;
    #1;
    checkOutput("resumed_eng_start", 32'(eng_start), 32'd1);
    tick();
    driveDone(32'h22222222, 2'd1);
    waitResp();
    finishResp();

    eng_done   = 1'b1;
    eng_result = 32'hDEADBEEF;
    tick();
    eng_done   = 1'b0;
    checkOutput("spurious_idle_busy", 32'(busy), 32'd0);
    checkOutput("spurious_idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("spurious_idle_resp_data", bus.resp_data, 32'h22222222);

    // backpressure with another requester pending and a spurious done in RESP
    applyStimulus(3, 32'h3E800000, 1'b0);
    waitReady(got);
    checkOutput("bp_req_ready", 32'(got), 32'h8);
    tick();
    applyStimulus(0, 32'h40000000, 1'b1);
    tick();
    driveDone(32'h3E7D4E1E, 2'd3);
    waitResp();
    for (int i = 0; i < 10; i++) begin
      eng_done   = (i == 4);
      eng_result = 32'hCAFEF00D;
      #1;
      checkOutput("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("bp_resp_data", bus.resp_data, 32'h3E7D4E1E);
      checkOutput("bp_resp_id", 32'(bus.resp_id), 32'd3);
      checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    eng_done = 1'b0;
    finishResp();
    waitReady(got);
    checkOutput("pending_grant", 32'(got), 32'h1);
    tick();
    bus.req_valid = '0;
    checkOutput("pending_eng_dataa", eng_dataa, 32'h40000000);
    tick();
    driveDone(32'h3F6ED9EC, 2'd0);
    waitResp();
    finishResp();

    // fairness from a fresh pointer with resp_ready tied high
    resetDut();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_dataa[32*i +: 32] = 32'hA0000000 + 32'(i);
      bus.req_cos[i] = i[0];
    end
    bus.req_valid  = 4'hF;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitReady(got);
      checkOutput($sformatf("fair_grant%0d", k), 32'(got), 32'(4'b0001 << (k % 4)));
      tick();
      checkOutput($sformatf("fair_dataa%0d", k), eng_dataa, 32'hA0000000 + 32'(k % 4));
      tick();
      driveDone(32'h00001000 + 32'(k), 2'(k % 4));
      checkOutput("fair_no_grant_in_resp", 32'(bus.req_ready), 32'd0);
      waitResp();
      if (k == 4) bus.req_valid = '0;
      tick();
    end
    bus.resp_ready = 1'b0;
    checkOutput("fair_idle", 32'(busy), 32'd0);

    // reset asserted during WAIT abandons the transaction
    applyStimulus(2, 32'h12345678, 1'b1);
    waitReady(got);
    checkOutput("rst_req_ready", 32'(got), 32'h4);
    tick();
    tick();
    checkOutput("rst_in_wait", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    bus.req_valid = '0;
    tick();
    reset = 1'b0;
    tick();
    eng_done   = 1'b1;
    eng_result = 32'hBADBAD00;
    tick();
    eng_done   = 1'b0;
    repeat (2) tick();
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("post_reset_resp_data", bus.resp_data, 32'd0);

`ifdef CORDIC_ARB_TIMEOUT_EN
    applyStimulus(1, 32'h3F000000, 1'b0);
    waitReady(got);
    checkOutput("to_req_ready", 32'(got), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("timeout_cycles", 32'(n), 32'd8);
    checkOutput("timeout_resp_data", bus.resp_data, 32'h7FC00000);
    checkOutput("timeout_resp_id", 32'(bus.resp_id), 32'd1);
    eng_done   = 1'b1;
    eng_result = 32'h3EF57744;
    tick();
    eng_done   = 1'b0;
    checkOutput("stale_done_resp_data", bus.resp_data, 32'h7FC00000);
    finishResp();
    checkOutput("timeout_idle", 32'(busy), 32'd0);
`else
    applyStimulus(1, 32'h3F000000, 1'b0);
    waitReady(got);
    checkOutput("nto_req_ready", 32'(got), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();
    n = 0;
    repeat (20) begin
      tick();
      n++;
    end
    checkOutput("no_timeout_busy", 32'(busy), 32'd1);
    checkOutput("no_timeout_resp_valid", 32'(bus.resp_valid), 32'd0);
    driveDone(32'h3EF57744, 2'd1);
    waitResp();
    finishResp();
`endif

    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
